mem_write_ctrl: RTL

Front-end controller that turns raw board switches and push-buttons into the data, store and addr signals consumed by the 4x8-bit memory system directly downstream. It synchronises and debounces the buttons, and generates one clean, fixed-width store strobe per press, with data and addr held stable around it. It manages the 2-bit address (manual step, optional auto-increment after a write) and an optional display-scan mode that walks addr for LED readback.

---
 rtl/mem_ctrl_pkg.sv | 13 +
 rtl/mem_write_ctrl_btn_debounce.sv | 50 +++++
 rtl/mem_write_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizes for the 4x8-bit memory write front-end.
package mem_ctrl_pkg;
  localparam int ADDR_W    = 2;
  localparam int DATA_W    = 8;
  localparam int NUM_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } wr_state_t;
endpackage

// File: rtl/mem_write_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, and a
// one-clock pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    // Count only while the synchronised level disagrees with the accepted one.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        pulse_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
endmodule

// File: rtl/mem_write_ctrl.sv
// Switch/button front-end producing data, store strobe and address for the
// downstream memory, with auto-increment and an LED readback scan mode.
module mem_write_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STORE_CYCLES    = 2,
  parameter int SCAN_PERIOD     = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw_data,
  input  logic       btn_store,
  input  logic       btn_next,
  input  logic       sw_auto_inc,
  input  logic       sw_scan,
  output logic [7:0] data_out,
  output logic       store_out,
  output logic [1:0] addr_out,
  output logic       busy
);
  localparam int STB_W  = (STORE_CYCLES > 1) ? $clog2(STORE_CYCLES) : 1;
  localparam int SCAN_W = $clog2(SCAN_PERIOD);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(STORE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

  logic store_req, next_req;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_store (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_store), .pulse(store_req)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_next), .pulse(next_req)
  );

  wr_state_t         state_q, state_d;
  logic [STB_W-1:0]  stb_cnt_q, stb_cnt_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              store_q, store_d;
  logic              busy_q, busy_d;
  logic [1:0]        auto_sync_q, auto_sync_d;
  logic [1:0]        scan_sync_q, scan_sync_d;
  logic              scan_step;

  always_comb begin
    state_d     = state_q;
    stb_cnt_d   = stb_cnt_q;
    scan_cnt_d  = scan_cnt_q;
    data_d      = data_q;
    addr_d      = addr_q;
    auto_sync_d = {auto_sync_q[0], sw_auto_inc};
    scan_sync_d = {scan_sync_q[0], sw_scan};
    scan_step   = 1'b0;

    // A terminal count coinciding with a store is held so the write keeps its address.
    if (!scan_sync_q[1]) begin
      scan_cnt_d = '0;
    end else if (state_q == IDLE) begin
      if (scan_cnt_q == SCAN_LAST) begin
        if (!store_req) begin
          scan_step  = 1'b1;
          scan_cnt_d = '0;
        end
      end else begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (store_req) begin
          state_d = SETUP;
          data_d  = sw_data;
        end else if (next_req || scan_step) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      SETUP: begin
        state_d   = STROBE;
        stb_cnt_d = '0;
      end
      STROBE: begin
        if (stb_cnt_q == STB_LAST) state_d = HOLD;
        else stb_cnt_d = stb_cnt_q + STB_W'(1);
      end
      HOLD: begin
        state_d = IDLE;
        if (auto_sync_q[1]) addr_d = addr_q + ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase

    store_d = (state_d == STROBE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stb_cnt_q   <= '0;
      scan_cnt_q  <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      store_q     <= 1'b0;
      busy_q      <= 1'b0;
      auto_sync_q <= '0;
      scan_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      stb_cnt_q   <= stb_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      busy_q      <= busy_d;
      auto_sync_q <= auto_sync_d;
      scan_sync_q <= scan_sync_d;
    end
  end

  assign data_out  = data_q;
  assign store_out = store_q;
  assign addr_out  = addr_q;
  assign busy      = busy_q;
endmodule
